// File: rtl/bus_responder_pkg.sv
// Shared types for the bus responder: FSM states, request/response bundles, widths.
// Struct widths follow the PKG_* localparams; the top's defaults match them.
package dut_pkg;

  localparam int PKG_AW       = 8;
  localparam int PKG_DW       = 32;
  localparam int PKG_BW       = PKG_DW / 8;
  localparam int PKG_NUM_REGS = 16;
  localparam int PKG_WAIT     = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic              write;
    logic [PKG_AW-1:0] addr;
    logic [PKG_DW-1:0] wdata;
    logic [PKG_BW-1:0] be;
  } req_t;

  typedef struct packed {
    logic [PKG_DW-1:0] rdata;
    logic              err;
  } rsp_t;

endpackage

// File: rtl/bus_responder_if.sv
// Valid/ready request/response bus between initiator (master) and responder (slave).
// Request: req_valid/ready/write/addr/wdata/be. Response: rsp_valid/ready/rdata/err.
interface bus_responder_if #(
  parameter int AW = dut_pkg::PKG_AW,
  parameter int DW = dut_pkg::PKG_DW
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW/8-1:0] req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_write, req_addr,
    output req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/bus_resp_reg_bank.sv
// NUM_REGS x DW register bank: byte-enable write port, combinational read port.
// Ports: clk, rst_n (sync clear), we/waddr/wdata/be, raddr/rdata.
module bus_resp_reg_bank #(
  parameter int DW       = 32,
  parameter int NUM_REGS = 16,
  parameter int IW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [IW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] be,
  input  logic [IW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < DW/8; b++)
        if (be[b])
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_responder.sv
// Bus responder: accepts one request, waits WAIT_CYCLES, answers from a reg bank.
// Ports: clk, rst_n (sync), bus (slave). Macro BUS_RESP_ADDR_ERR_EN: range check.
module bus_responder
  import dut_pkg::*;
#(
  parameter int AW          = PKG_AW,
  parameter int DW          = PKG_DW,
  parameter int NUM_REGS    = PKG_NUM_REGS,
  parameter int WAIT_CYCLES = PKG_WAIT
) (
  input logic            clk,
  input logic            rst_n,
  bus_responder_if.slave bus
);

  localparam int IW = $clog2(NUM_REGS);
  localparam logic [3:0] CNT_INIT =
    4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e state_q, state_d;
  logic [3:0] cnt_q;
  req_t req_q, cur;
  rsp_t rsp_q;
  logic acc, to_resp, err, wr_en;
  logic [IW-1:0] idx;
  logic [DW-1:0] rd_data;
  logic unused_addr;

  // In IDLE the request is taken straight from the bus so a
  // zero-wait transfer can hit the bank on the accept edge.
  always_comb begin
    cur = req_q;
    if (state_q == IDLE) begin
      cur.write = bus.req_write;
      cur.addr  = bus.req_addr;
      cur.wdata = bus.req_wdata;
      cur.be    = bus.req_be;
    end
  end

  assign acc     = bus.req_valid && (state_q == IDLE);
  assign to_resp = (state_d == RESP) && (state_q != RESP);
  assign idx     = cur.addr[IW-1:0];
  assign unused_addr = ^cur.addr[AW-1:IW];

`ifdef BUS_RESP_ADDR_ERR_EN
  assign err = 32'(cur.addr) >= 32'(NUM_REGS);
`else
  assign err = 1'b0;
`endif

  assign wr_en = to_resp && cur.write && !err;

  bus_resp_reg_bank #(
    .DW       (DW),
    .NUM_REGS (NUM_REGS)
  ) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (idx),
    .wdata (cur.wdata),
    .be    (cur.be),
    .raddr (idx),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (acc)
              state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT: if (cnt_q == '0) state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_rdata = rsp_q.rdata;
    bus.rsp_err   = rsp_q.err;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      req_q <= '0;
      rsp_q <= '0;
    end else begin
      if (acc) begin
        req_q <= cur;
        cnt_q <= CNT_INIT;
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (to_resp) begin
        rsp_q.rdata <= (err || cur.write) ? '0 : rd_data;
        rsp_q.err   <= err;
      end else if (state_q == RESP && bus.rsp_ready) begin
        rsp_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: ua uses WAIT_CYCLES=2, ub uses 0.
// Follows the BUS_RESP_ADDR_ERR_EN setting of the build.
module tb_bus_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_responder_if #(.AW(8), .DW(32)) ia ();
  bus_responder_if #(.AW(8), .DW(32)) ib ();

  bus_responder #(
    .AW(8), .DW(32), .NUM_REGS(16), .WAIT_CYCLES(2)
  ) ua (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia.slave)
  );

  bus_responder #(
    .AW(8), .DW(32), .NUM_REGS(16), .WAIT_CYCLES(0)
  ) ub (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib.slave)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input bit s);
    return s ? ib.req_ready : ia.req_ready;
  endfunction

  function automatic logic vld(input bit s);
    return s ? ib.rsp_valid : ia.rsp_valid;
  endfunction

  function automatic logic [31:0] rdat(input bit s);
    return s ? ib.rsp_rdata : ia.rsp_rdata;
  endfunction

  function automatic logic rerr(input bit s);
    return s ? ib.rsp_err : ia.rsp_err;
  endfunction

  task automatic drive(input bit s, input logic v, input logic wr,
                       input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    if (s) begin
      ib.req_valid = v; ib.req_write = wr;
      ib.req_addr = a; ib.req_wdata = d; ib.req_be = be;
    end else begin
      ia.req_valid = v; ia.req_write = wr;
      ia.req_addr = a; ia.req_wdata = d; ia.req_be = be;
    end
  endtask

  task automatic set_rr(input bit s, input logic v);
    if (s) ib.rsp_ready = v;
    else   ia.rsp_ready = v;
  endtask

  // Called #1 after a rising edge. exp_cyc counts cycles from the
  // accept cycle to the first cycle with rsp_valid high.
  task automatic txn(input string tag, input bit s, input logic wr,
                     input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [31:0] exp_rd,
                     input logic exp_err, input int exp_cyc,
                     input int hold);
    int n;
    drive(s, 1'b1, wr, a, d, be);
    n = 0;
    while (!rdy(s) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!rdy(s)) begin
      check({tag, "_rdy_timeout"}, 32'(rdy(s)), 32'd1);
      drive(s, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
      return;
    end
    @(posedge clk); #1;
    drive(s, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    n = 0;
    while (!vld(s) && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_cyc"}, 32'(n + 1), 32'(exp_cyc));
    if (!vld(s)) return;
    check({tag, "_rdata"}, rdat(s), exp_rd);
    check({tag, "_err"}, 32'(rerr(s)), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_vld"}, 32'(vld(s)), 32'd1);
      check({tag, "_hold_rdy"}, 32'(rdy(s)), 32'd0);
      check({tag, "_hold_rdata"}, rdat(s), exp_rd);
    end
    set_rr(s, 1'b1);
    @(posedge clk); #1;
    set_rr(s, 1'b0);
    check({tag, "_done_vld"}, 32'(vld(s)), 32'd0);
    check({tag, "_done_rdy"}, 32'(rdy(s)), 32'd1);
    check({tag, "_done_rdata"}, rdat(s), 32'd0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    set_rr(1'b0, 1'b0);
    set_rr(1'b1, 1'b0);

    // reset held for three edges
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", 32'(ia.req_ready), 32'd1);
    check("rst_vld", 32'(ia.rsp_valid), 32'd0);
    check("rst_rdata", ia.rsp_rdata, 32'd0);
    check("rst_err", 32'(ia.rsp_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn("rd5_rst", 1'b0, 1'b0, 8'h05, 32'h0, 4'h0,
        32'h0, 1'b0, 3, 0);

    // full write then read back
    txn("wr3", 1'b0, 1'b1, 8'h03, 32'hDEADBEEF, 4'hF,
        32'h0, 1'b0, 3, 0);
    txn("rd3", 1'b0, 1'b0, 8'h03, 32'h0, 4'h0,
        32'hDEADBEEF, 1'b0, 3, 0);

    // byte enables 0101
    txn("wr3_be", 1'b0, 1'b1, 8'h03, 32'h11223344, 4'b0101,
        32'h0, 1'b0, 3, 0);
    txn("rd3_be", 1'b0, 1'b0, 8'h03, 32'h0, 4'h0,
        32'hDE22BE44, 1'b0, 3, 0);

    // be=0 no-op write
    txn("wr7_nobe", 1'b0, 1'b1, 8'h07, 32'hFFFFFFFF, 4'h0,
        32'h0, 1'b0, 3, 0);
    txn("rd7_nobe", 1'b0, 1'b0, 8'h07, 32'h0, 4'h0,
        32'h0, 1'b0, 3, 0);

    // backpressure for ten cycles
    txn("rd3_bp", 1'b0, 1'b0, 8'h03, 32'h0, 4'h0,
        32'hDE22BE44, 1'b0, 3, 10);

    // out-of-range address
`ifdef BUS_RESP_ADDR_ERR_EN
    txn("wr13", 1'b0, 1'b1, 8'h13, 32'h55, 4'hF,
        32'h0, 1'b1, 3, 0);
    txn("rd3_oor", 1'b0, 1'b0, 8'h03, 32'h0, 4'h0,
        32'hDE22BE44, 1'b0, 3, 0);
    txn("rd13", 1'b0, 1'b0, 8'h13, 32'h0, 4'h0,
        32'h0, 1'b1, 3, 0);
`else
    txn("wr13", 1'b0, 1'b1, 8'h13, 32'h55, 4'hF,
        32'h0, 1'b0, 3, 0);
    txn("rd3_oor", 1'b0, 1'b0, 8'h03, 32'h0, 4'h0,
        32'h55, 1'b0, 3, 0);
    txn("rd13", 1'b0, 1'b0, 8'h13, 32'h0, 4'h0,
        32'h55, 1'b0, 3, 0);
`endif

    // reset while in WAIT
    drive(1'b0, 1'b1, 1'b1, 8'h03, 32'hFFFFFFFF, 4'hF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    check("mid_wait_rdy", 32'(ia.req_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_vld", 32'(ia.rsp_valid), 32'd0);
    check("mid_rst_rdy", 32'(ia.req_ready), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check("mid_rst_quiet", 32'(ia.rsp_valid), 32'd0);
    end
    txn("rd3_clr", 1'b0, 1'b0, 8'h03, 32'h0, 4'h0,
        32'h0, 1'b0, 3, 0);

    // zero-wait instance
    txn("z_wr3", 1'b1, 1'b1, 8'h03, 32'hDEADBEEF, 4'hF,
        32'h0, 1'b0, 1, 0);
    txn("z_rd3", 1'b1, 1'b0, 8'h03, 32'h0, 4'h0,
        32'hDEADBEEF, 1'b0, 1, 0);
    txn("z_rd3_bp", 1'b1, 1'b0, 8'h13, 32'h0, 4'h0,
`ifdef BUS_RESP_ADDR_ERR_EN
        32'h0, 1'b1, 1, 2);
`else
        32'hDEADBEEF, 1'b0, 1, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
